// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes,
// default latencies and the sequencer state type.
package mdu_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MTHI  = 4'd4;
  localparam logic [3:0] MDU_MTLO  = 4'd5;
  localparam logic [3:0] MDU_MADD  = 4'd8;
  localparam logic [3:0] MDU_MADDU = 4'd9;
  localparam logic [3:0] MDU_MSUB  = 4'd10;
  localparam logic [3:0] MDU_MSUBU = 4'd11;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic {IDLE, RUN} mdu_state_e;

endpackage

// File: rtl/ex_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. Define MDU_MADD_EN to
// accept the MADD/MADDU/MSUB/MSUBU accumulate ops (otherwise they are no-ops).
module ex_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiSel,
  output logic        Busy,
  output logic [31:0] Out
);

`ifdef MDU_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  mdu_state_e  state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] opA_q, opB_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q;

  logic [63:0]        prodS, prodU, resHiLo;
  logic [31:0]        bSafe, uQuo, uRem;
  logic signed [31:0] sQuo, sRem;
  logic               divOvf, commitEn;

  // Result is formed from the latched operands; the counter only models latency.
  always_comb begin
    prodS    = $signed({{32{opA_q[31]}}, opA_q}) * $signed({{32{opB_q[31]}}, opB_q});
    prodU    = {32'd0, opA_q} * {32'd0, opB_q};
    bSafe    = (opB_q == 32'd0) ? 32'd1 : opB_q;
    divOvf   = (opA_q == 32'h8000_0000) && (opB_q == 32'hFFFF_FFFF);
    sQuo     = divOvf ? 32'sh8000_0000 : $signed(opA_q) / $signed(bSafe);
    sRem     = divOvf ? 32'sd0 : $signed(opA_q) % $signed(bSafe);
    uQuo     = opA_q / bSafe;
    uRem     = opA_q % bSafe;
    commitEn = 1'b1;
    resHiLo  = {hi_q, lo_q};
    case (op_q)
      MDU_MULT:  resHiLo = prodS;
      MDU_MULTU: resHiLo = prodU;
      MDU_DIV:   begin resHiLo = {sRem, sQuo}; commitEn = (opB_q != 32'd0); end
      MDU_DIVU:  begin resHiLo = {uRem, uQuo}; commitEn = (opB_q != 32'd0); end
      MDU_MADD:  resHiLo = {hi_q, lo_q} + prodS;
      MDU_MADDU: resHiLo = {hi_q, lo_q} + prodU;
      MDU_MSUB:  resHiLo = {hi_q, lo_q} - prodS;
      MDU_MSUBU: resHiLo = {hi_q, lo_q} - prodU;
      default:   commitEn = 1'b0;
    endcase
  end

  // HI/LO cannot change while RUN, so the accumulate base read at commit
  // equals the value present at Start.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      op_q    <= 4'd0;
      opA_q   <= 32'd0;
      opB_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            case (Op)
              MDU_MULT, MDU_MULTU: begin
                op_q <= Op; opA_q <= A; opB_q <= B;
                cnt_q <= 8'(MULT_CYCLES); state_q <= RUN; busy_q <= 1'b1;
              end
              MDU_DIV, MDU_DIVU: begin
                op_q <= Op; opA_q <= A; opB_q <= B;
                cnt_q <= 8'(DIV_CYCLES); state_q <= RUN; busy_q <= 1'b1;
              end
              MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
                if (MaddEn) begin
                  op_q <= Op; opA_q <= A; opB_q <= B;
                  cnt_q <= 8'(MULT_CYCLES); state_q <= RUN; busy_q <= 1'b1;
                end
              end
              MDU_MTHI: hi_q <= A;
              MDU_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt_q == 8'd1) begin
            if (commitEn) begin
              hi_q <= resHiLo[63:32];
              lo_q <= resHiLo[31:0];
            end
            cnt_q   <= 8'd0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy = busy_q;
  assign Out  = HiSel ? hi_q : lo_q;

endmodule
